barrel_shift_pipe_ctrl: RTL and testbench

- Pipelined front-end and sequencer for the 16-bit barrel shifter datapath.
- Accepts shift operations over a valid/ready handshake and pre-conditions the operand (bit reversal for right shifts, inversion for negative arithmetic right shifts).
- Drives per-stage select vectors for four left-shift mux stages (by 1, 2, 4, 8), registers between stages and post-conditions the result.
- Sits between the ALU operand/decode stage (upstream) and the ALU result mux (downstream).

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_stage_reg.sv | 34 +++
 rtl/barrel_shift_pipe_ctrl.sv | 76 +++++++
 tb/tb_barrel_shift_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types, constants and helpers for the pipelined 16-bit barrel shifter.
package shift_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;
  localparam int NSTAGES = SHAMT_W;

  typedef struct packed {
    logic [SHAMT_W-1:0] amount;
    logic               dir;
    logic               inv;
  } shift_ctl_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    shift_ctl_t       ctl;
  } stage_t;

  function automatic logic [WIDTH-1:0] bit_reverse16(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

  // A set select bit passes the bit through; a clear bit takes the shifted value.
  function automatic logic [WIDTH-1:0] stage_select(input int k, input logic [SHAMT_W-1:0] amount);
    return {WIDTH{~amount[k]}};
  endfunction

endpackage

// File: rtl/shift_stage_reg.sv
// One left-shift mux stage (shift by 2^K) followed by its pipeline register.
module shift_stage_reg
  import shift_pkg::*;
#(
  parameter int K = 0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  input  stage_t d,
  output stage_t q
);

  localparam int SHIFT = 1 << K;

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] muxed;

  assign sel     = stage_select(K, d.ctl.amount);
  assign shifted = d.data << SHIFT;
  assign muxed   = (d.data & sel) | (shifted & ~sel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (advance) begin
      q.valid <= d.valid;
      q.data  <= muxed;
      q.ctl   <= d.ctl;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe_ctrl.sv
// Four-stage pipelined barrel shifter: right shifts run as reversed left shifts,
// negative arithmetic right shifts run on the inverted operand.
module barrel_shift_pipe_ctrl
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  logic              in_dir,
  input  logic              in_arith,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // the pipeline moves as one (global stall), so in_ready depends only on S4 and out_ready.
  stage_t           s_in;
  stage_t           s_q [NSTAGES];
  stage_t           last;
  logic             inv;
  logic             advance;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  assign inv      = in_dir & in_arith & in_data[WIDTH-1];
  assign x        = in_data ^ {WIDTH{inv}};
  assign advance  = ~s_q[NSTAGES-1].valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    s_in            = '0;
    s_in.valid      = in_valid & advance;
    s_in.data       = in_dir ? bit_reverse16(x) : x;
    s_in.ctl.amount = in_amount;
    s_in.ctl.dir    = in_dir;
    s_in.ctl.inv    = inv;
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_stage_reg #(.K(k)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .d       (s_in),
        .q       (s_q[k])
      );
    end else begin : g_next
      shift_stage_reg #(.K(k)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .d       (s_q[k-1]),
        .q       (s_q[k])
      );
    end
  end

  assign last      = s_q[NSTAGES-1];
  assign y         = last.ctl.dir ? bit_reverse16(last.data) : last.data;
  assign out_data  = y ^ {WIDTH{last.ctl.inv}};
  assign out_valid = last.valid;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < NSTAGES; k++) begin
      busy = busy | s_q[k].valid;
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe_ctrl.sv
// Directed vector table, multi-cycle corner sequences and a random run checked by a scoreboard.
module tb_barrel_shift_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_amount = '0;
  logic        in_dir = 1'b0;
  logic        in_arith = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_cons = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] data;
    logic [3:0]  amount;
    logic        dir;
    logic        arith;
    logic [15:0] expd;
  } vec_t;

  vec_t vecs [10];

  // ---------------- clock / reset
  always #5 clk = ~clk;

  barrel_shift_pipe_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_dir    (in_dir),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] amt,
                                            input logic dir, input logic arith);
    if (!dir) return d << amt;
    if (arith) return 16'($signed(d) >>> amt);
    return d >> amt;
  endfunction

  // ---------------- scoreboard: sample mid-cycle, transfers happen on the next rising edge
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h, want nothing (t=%0t)", out_data, $time);
        end else begin
          check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back(ref_shift(in_data, in_amount, in_dir, in_arith));
      end
    end
  end

  // ---------------- driver tasks
  task automatic drive_op(input logic [15:0] d, input logic [3:0] a, input logic dir, input logic ar);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_dir    = dir;
    in_arith  = ar;
  endtask

  task automatic run_table();
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive_op(vecs[v].data, vecs[v].amount, vecs[v].dir, vecs[v].arith);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("vec%0d_latency_c%0d", v, c), 32'(out_valid), 32'(c == 3));
        if (c < 3) @(posedge clk);
      end
      check($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].expd));
    end
    @(posedge clk); #1;
  endtask

  task automatic run_backpressure();
    out_ready = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      drive_op(16'h0001, 4'(a), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_in_ready_stalled", 32'(in_ready), 32'd0);
      check("bp_out_valid_stalled", 32'(out_valid), 32'd1);
      check("bp_out_data_held", 32'(out_data), 32'h0002);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_drain_valid", 32'(out_valid), 32'd1);
      check("bp_drain_data", 32'(out_data), 32'h0002 << i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_empty_after", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_reset_midflight();
    out_ready = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      drive_op(16'h0100, 4'(a), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_out_valid", 32'(out_valid), 32'd1);
    check("rst_pre_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_in_ready", 32'(in_ready), 32'd1);
    check("rst_async_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    out_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_random();
    int   acc0;
    int   cons0;
    int   cyc;
    logic took;
    acc0  = n_acc;
    cons0 = n_cons;
    cyc   = 0;
    while ((n_acc - acc0) < 10000 && cyc < 60000) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (!in_valid || took) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 16'($urandom);
        in_amount = 4'($urandom_range(0, 15));
        in_dir    = 1'($urandom_range(0, 1));
        in_arith  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_budget", 32'((n_acc - acc0) >= 10000), 32'd1);
    for (int i = 0; i < 50 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("rand_drained", 32'(busy), 32'd0);
    check("rand_acc_eq_cons", 32'(n_cons - cons0), 32'(n_acc - acc0));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence
  initial begin
    vecs[0] = '{16'h0001, 4'd5,  1'b0, 1'b0, 16'h0020};
    vecs[1] = '{16'h8000, 4'd15, 1'b1, 1'b0, 16'h0001};
    vecs[2] = '{16'hA5A5, 4'd0,  1'b1, 1'b0, 16'hA5A5};
    vecs[3] = '{16'h8010, 4'd4,  1'b1, 1'b1, 16'hF801};
    vecs[4] = '{16'h4000, 4'd2,  1'b1, 1'b1, 16'h1000};
    vecs[5] = '{16'h0003, 4'd1,  1'b0, 1'b1, 16'h0006};
    vecs[6] = '{16'hA5A5, 4'd0,  1'b1, 1'b1, 16'hA5A5};
    vecs[7] = '{16'hFFFF, 4'd15, 1'b0, 1'b0, 16'h8000};
    vecs[8] = '{16'h8001, 4'd1,  1'b1, 1'b1, 16'hC000};
    vecs[9] = '{16'h1234, 4'd8,  1'b1, 1'b0, 16'h0012};

    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;

    run_table();
    run_backpressure();
    run_reset_midflight();
    run_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
